// File: rtl/bp_fe_pkg.sv
// Front-end shared definitions: the BTB write-update record and its macros.
// The record is parameterised by address/tag/index widths, so it is declared
// through a macro inside each user module rather than as a fixed package type.
`ifndef BP_FE_PKG_SV
`define BP_FE_PKG_SV

`define DECLARE_BP_FE_BTB_WR_S(vaddr_width_mp, btb_tag_width_mp, btb_idx_width_mp) \
  typedef struct packed {                          \
    logic                          clr;            \
    logic                          jmp;            \
    logic [btb_tag_width_mp-1:0]   tag;            \
    logic [btb_idx_width_mp-1:0]   idx;            \
    logic [vaddr_width_mp-1:0]     tgt;            \
  } bp_fe_btb_wr_s

`define BP_FE_BTB_WR_WIDTH(vaddr_width_mp, btb_tag_width_mp, btb_idx_width_mp) \
  (bp_fe_pkg::btb_wr_ctrl_width_gp + (btb_tag_width_mp) + (btb_idx_width_mp) + (vaddr_width_mp))

package bp_fe_pkg;

  // Control bits carried with every BTB update: clr and jmp.
  localparam int btb_wr_ctrl_width_gp = 2;

endpackage

`endif

// File: rtl/bsg_circular_ptr.sv
// Circular pointer over a power-of-two number of slots. Advances by add_i
// each cycle; n_o is the value the pointer takes on the next edge.
module bsg_circular_ptr #(
  parameter int slots_p     = 4,
  parameter int max_add_p   = 1,
  localparam int ptr_width_lp = (slots_p > 1) ? $clog2(slots_p) : 1,
  localparam int add_width_lp = (max_add_p > 0) ? $clog2(max_add_p + 1) : 1
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic [add_width_lp-1:0] add_i,
  output logic [ptr_width_lp-1:0] o,
  output logic [ptr_width_lp-1:0] n_o
);

  logic [ptr_width_lp-1:0] ptr_q;

  // Power-of-two slot count: wrap is plain truncation, and adding slots_p
  // (a full lap) truncates to zero, returning the pointer to itself.
  assign n_o = ptr_q + ptr_width_lp'(add_i);
  assign o   = ptr_q;

  // Pointer register, cleared asynchronously.
  always_ff @(posedge clk or posedge reset_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= n_o;
  end

endmodule

// File: rtl/bp_fe_btb_wr_queue.sv
// Coalescing write queue in front of the BTB write port. Updates are held in
// a circular FIFO and drained one per cycle while the BTB is ready. A new
// update whose index matches a pending non-head entry overwrites it in place,
// so non-head entries always carry distinct indices. The head is never
// rewritten because it may be on the write port this very cycle.
module bp_fe_btb_wr_queue
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p   = 39,
  parameter int btb_tag_width_p = 9,
  parameter int btb_idx_width_p = 6,
  parameter int els_p           = 4,
  localparam int ptr_width_lp   = $clog2(els_p),
  localparam int count_width_lp = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,

  input  logic                       v_i,
  output logic                       ready_o,
  input  logic                       clr_i,
  input  logic                       jmp_i,
  input  logic [btb_tag_width_p-1:0] tag_i,
  input  logic [btb_idx_width_p-1:0] idx_i,
  input  logic [vaddr_width_p-1:0]   tgt_i,

  input  logic                       flush_i,
  input  logic                       btb_ready_i,

  output logic                       w_v_o,
  output logic                       w_clr_o,
  output logic                       w_jmp_o,
  output logic [btb_tag_width_p-1:0] w_tag_o,
  output logic [btb_idx_width_p-1:0] w_idx_o,
  output logic [vaddr_width_p-1:0]   w_tgt_o,

  output logic [count_width_lp-1:0]  count_o
);

  `DECLARE_BP_FE_BTB_WR_S(vaddr_width_p, btb_tag_width_p, btb_idx_width_p);
  localparam int entry_width_lp = `BP_FE_BTB_WR_WIDTH(vaddr_width_p, btb_tag_width_p, btb_idx_width_p);

  logic [ptr_width_lp-1:0]   head_ptr, tail_ptr;
  logic [ptr_width_lp-1:0]   head_ptr_n, tail_ptr_n;
  logic [count_width_lp-1:0] head_add;
  logic [count_width_lp-1:0] count_q, count_d;
  logic [els_p-1:0]          valid_q, valid_d;
  logic [entry_width_lp-1:0] mem_q [els_p];

  bp_fe_btb_wr_s             ent_r [els_p];
  bp_fe_btb_wr_s             head_r, entry_in;
  logic [els_p-1:0]          hit_vec;
  logic [ptr_width_lp-1:0]   hit_idx;
  logic                      nonhead_hit;
  logic                      full, pop, accept, enq_new, coalesce;

  // On flush the head jumps over every pending entry so it meets the tail.
  bsg_circular_ptr #(.slots_p(els_p), .max_add_p(els_p)) head_ptr_inst (
    .clk     (clk_i),
    .reset_i (reset_i),
    .add_i   (head_add),
    .o       (head_ptr),
    .n_o     (head_ptr_n)
  );

  bsg_circular_ptr #(.slots_p(els_p), .max_add_p(1)) tail_ptr_inst (
    .clk     (clk_i),
    .reset_i (reset_i),
    .add_i   (enq_new),
    .o       (tail_ptr),
    .n_o     (tail_ptr_n)
  );

  assign entry_in = '{clr: clr_i, jmp: jmp_i, tag: tag_i, idx: idx_i, tgt: tgt_i};

  // Index CAM over the non-head entries; at most one can match.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < els_p; i++) begin
      ent_r[i]   = mem_q[i];
      hit_vec[i] = valid_q[i] & (ptr_width_lp'(i) != head_ptr) & (ent_r[i].idx == idx_i);
      if (hit_vec[i]) hit_idx = ptr_width_lp'(i);
    end
  end

  assign nonhead_hit = |hit_vec;
  assign full        = (count_q == count_width_lp'(els_p));

  // Acceptance ignores btb_ready_i: a slot freed by this cycle's drain is
  // not offered until the count reflects it.
  assign ready_o  = ~reset_i & ~flush_i & (~full | nonhead_hit);
  assign accept   = v_i & ready_o;
  assign enq_new  = accept & ~nonhead_hit;
  assign coalesce = accept &  nonhead_hit;

  assign head_r  = ent_r[head_ptr];
  assign pop     = (count_q != '0) & btb_ready_i & ~flush_i;
  assign w_v_o   = pop;
  assign w_clr_o = head_r.clr;
  assign w_jmp_o = head_r.jmp;
  assign w_tag_o = head_r.tag;
  assign w_idx_o = head_r.idx;
  assign w_tgt_o = head_r.tgt;
  assign count_o = count_q;

  assign head_add = flush_i ? count_q : count_width_lp'(pop);

  // Next occupancy and per-entry valid bits.
  always_comb begin
    count_d = count_q;
    valid_d = valid_q;
    if (flush_i) begin
      count_d = '0;
      valid_d = '0;
    end else begin
      count_d = count_q + count_width_lp'(enq_new) - count_width_lp'(pop);
      if (pop)     valid_d[head_ptr] = 1'b0;
      if (enq_new) valid_d[tail_ptr] = 1'b1;
    end
  end

  // Occupancy and valid flops, cleared asynchronously.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
      valid_q <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage: append at the tail or rewrite the matching entry.
  always_ff @(posedge clk_i) begin
    // NOTE: payload flops carry no reset; the valid bits and count alone
    // decide whether an entry is live, so stale payload is never observed.
    if (enq_new)       mem_q[tail_ptr] <= entry_in;
    else if (coalesce) mem_q[hit_idx]  <= entry_in;
  end

endmodule
